// File: rtl/md_pkg.sv
// Shared opcodes, widths and default latencies for the HI/LO multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_OP_W      = 4;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

endpackage

// File: rtl/md_core.sv
// Combinational HI/LO arithmetic: result, commit enable and op-class decode.
// MD_MADD_EN adds the madd/maddu/msub/msubu accumulate ops.
module md_core
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [DATA_W-1:0]  rs,
    input  logic [DATA_W-1:0]  rt,
    input  logic [DATA_W-1:0]  hi,
    input  logic [DATA_W-1:0]  lo,
    output hilo_t              res_c,
    output logic               commit_c,
    output logic               mul_op_c,
    output logic               div_op_c
);

    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [DATA_W-1:0]   dvs_s;
    logic [DATA_W-1:0]   dvs_u;
    logic [DATA_W-1:0]   q_s;
    logic [DATA_W-1:0]   r_s;
    logic [DATA_W-1:0]   q_u;
    logic [DATA_W-1:0]   r_u;
    logic                div_ovf;
`ifdef MD_MADD_EN
    logic [2*DATA_W-1:0] acc;
`endif

    // Divisors are forced to 1 for /0 (result discarded) and for MIN/-1,
    // where dividing by 1 yields exactly the required quotient MIN, remainder 0.
    always_comb begin
        prod_s  = $signed({{DATA_W{rs[DATA_W-1]}}, rs}) * $signed({{DATA_W{rt[DATA_W-1]}}, rt});
        prod_u  = {{DATA_W{1'b0}}, rs} * {{DATA_W{1'b0}}, rt};
        div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
        dvs_s   = ((rt == '0) || div_ovf) ? DATA_W'(1) : rt;
        dvs_u   = (rt == '0) ? DATA_W'(1) : rt;
        q_s     = $signed(rs) / $signed(dvs_s);
        r_s     = $signed(rs) % $signed(dvs_s);
        q_u     = rs / dvs_u;
        r_u     = rs % dvs_u;
`ifdef MD_MADD_EN
        acc     = {hi, lo};
`endif
    end

    always_comb begin
        res_c    = '{hi: hi, lo: lo};
        commit_c = 1'b0;
        mul_op_c = 1'b0;
        div_op_c = 1'b0;
        case (op)
            MD_MULT:  begin res_c = prod_s; commit_c = 1'b1; mul_op_c = 1'b1; end
            MD_MULTU: begin res_c = prod_u; commit_c = 1'b1; mul_op_c = 1'b1; end
            MD_DIV:   begin res_c = '{hi: r_s, lo: q_s}; commit_c = (rt != '0); div_op_c = 1'b1; end
            MD_DIVU:  begin res_c = '{hi: r_u, lo: q_u}; commit_c = (rt != '0); div_op_c = 1'b1; end
`ifdef MD_MADD_EN
            MD_MADD:  begin res_c = acc + prod_s; commit_c = 1'b1; mul_op_c = 1'b1; end
            MD_MADDU: begin res_c = acc + prod_u; commit_c = 1'b1; mul_op_c = 1'b1; end
            MD_MSUB:  begin res_c = acc - prod_s; commit_c = 1'b1; mul_op_c = 1'b1; end
            MD_MSUBU: begin res_c = acc - prod_u; commit_c = 1'b1; mul_op_c = 1'b1; end
`endif
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer: issue, fixed-latency busy window, HI/LO commit.
// Build option MD_MADD_EN enables the multiply-accumulate ops in md_core.
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    output logic               busy,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo
);

    localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    hilo_t             tmp, tmp_nxt, res_c;
    logic              tmp_cmt, tmp_cmt_nxt;
    logic              busy_nxt;
    logic [DATA_W-1:0] hi_nxt, lo_nxt;
    logic              commit_c, mul_op_c, div_op_c;

    md_core u_core (
        .op       (md_op),
        .rs       (rs_data),
        .rt       (rt_data),
        .hi       (hi),
        .lo       (lo),
        .res_c    (res_c),
        .commit_c (commit_c),
        .mul_op_c (mul_op_c),
        .div_op_c (div_op_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            tmp     <= '0;
            tmp_cmt <= 1'b0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tmp     <= tmp_nxt;
            tmp_cmt <= tmp_cmt_nxt;
            busy    <= busy_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
        end
    end

    // Ops arriving in RUN belong to stalled instructions and are never acted on.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tmp_nxt     = tmp;
        tmp_cmt_nxt = tmp_cmt;
        busy_nxt    = busy;
        hi_nxt      = hi;
        lo_nxt      = lo;
        case (state)
            IDLE: begin
                if (!req) begin
                    if (mul_op_c || div_op_c) begin
                        state_nxt   = RUN;
                        cnt_nxt     = mul_op_c ? MULT_LAT_C : DIV_LAT_C;
                        busy_nxt    = 1'b1;
                        tmp_nxt     = res_c;
                        tmp_cmt_nxt = commit_c;
                    end else if (md_op == MD_MTHI) begin
                        hi_nxt = rs_data;
                    end else if (md_op == MD_MTLO) begin
                        lo_nxt = rs_data;
                    end
                end
            end
            RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    if (tmp_cmt) begin
                        hi_nxt = tmp.hi;
                        lo_nxt = tmp.lo;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
